// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl -- trap sequencer driving the CSR file's secondary (clint) write
// port.
//
// On ecall, ebreak, mret or a pending enabled interrupt it stalls the
// pipeline and issues the required CSR writes, one per cycle:
//   trap/interrupt : mepc, then mstatus, then mcause, then a redirect to mtvec
//   mret           : mstatus restore, then a redirect to mepc
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   ecall_i, ebreak_i  synchronous trap requests from ex
//   mret_i             trap return from ex
//   inst_addr_i        pc of the instruction in ex
//   jump_flag_i/addr_i redirect that ex is performing this cycle
//   int_flag_i         level interrupt requests, bit0 = timer
//   global_int_en_i    mstatus.MIE
//   csr_mtvec_i, csr_mepc_i, csr_mstatus_i   current CSR values
//   we_o, waddr_o, data_o   CSR write port (zero when idle)
//   hold_flag_o        pipeline stall request
//   int_assert_o       one-cycle redirect strobe
//   int_addr_o         redirect target (zero when not asserting)
// ---------------------------------------------------------------------------
module trap_ctrl #(
  parameter logic [31:0] CAUSE_ECALL  = 32'h0000000B,
  parameter logic [31:0] CAUSE_EBREAK = 32'h00000003,
  parameter logic [31:0] CAUSE_TIMER  = 32'h80000007,
  parameter logic [31:0] CAUSE_EXT    = 32'h8000000B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [7:0]  int_flag_i,
  input  logic        global_int_en_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] data_o,
  output logic        hold_flag_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam logic [31:0] ADDR_MSTATUS = 32'h00000300;
  localparam logic [31:0] ADDR_MEPC    = 32'h00000341;
  localparam logic [31:0] ADDR_MCAUSE  = 32'h00000342;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_MEPC    = 3'd1,
    W_MSTATUS = 3'd2,
    W_MCAUSE  = 3'd3,
    W_MRET    = 3'd4,
    ASSERT    = 3'd5
  } state_t;

  state_t      state_r;
  logic [31:0] cause_r;
  logic        we_r;
  logic [31:0] waddr_r;
  logic [31:0] data_r;
  logic        int_assert_r;
  logic [31:0] int_addr_r;

  logic        sync_trap_s;
  logic        int_go_s;
  logic        trigger_s;
  logic [31:0] int_epc_s;
  logic [31:0] int_cause_s;

  // Trap entry: save MIE into MPIE and disable interrupts.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r    = ms;
    r[7] = ms[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE and set MPIE.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r    = ms;
    r[3] = ms[7];
    r[7] = 1'b1;
    return r;
  endfunction

  // Trigger decode; only meaningful while IDLE. Priority: sync trap, mret, irq.
  always_comb begin
    sync_trap_s = ecall_i | ebreak_i;
    int_go_s    = (int_flag_i != 8'h00) & global_int_en_i;
    trigger_s   = (state_r == IDLE) & (sync_trap_s | mret_i | int_go_s);
    // An interrupt taken while ex redirects must resume at the redirect target.
    int_epc_s   = jump_flag_i ? jump_addr_i : inst_addr_i;
    int_cause_s = int_flag_i[0] ? CAUSE_TIMER : CAUSE_EXT;
  end

  // Stall is combinational so the trigger cycle already suppresses ex writes.
  assign hold_flag_o = (state_r != IDLE) | trigger_s;

  assign we_o         = we_r;
  assign waddr_o      = waddr_r;
  assign data_o       = data_r;
  assign int_assert_o = int_assert_r;
  assign int_addr_o   = int_addr_r;

  // Sequencer: outputs are registered alongside the state they belong to,
  // so each write is prepared in the cycle before it appears on the port.
  // CSR inputs are stable meanwhile since hold blocks every other writer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cause_r      <= 32'h00000000;
      we_r         <= 1'b0;
      waddr_r      <= 32'h00000000;
      data_r       <= 32'h00000000;
      int_assert_r <= 1'b0;
      int_addr_r   <= 32'h00000000;
    end else begin
      we_r         <= 1'b0;
      waddr_r      <= 32'h00000000;
      data_r       <= 32'h00000000;
      int_assert_r <= 1'b0;
      int_addr_r   <= 32'h00000000;
      case (state_r)
        IDLE: begin
          if (sync_trap_s) begin
            cause_r <= ecall_i ? CAUSE_ECALL : CAUSE_EBREAK;
            state_r <= W_MEPC;
            we_r    <= 1'b1;
            waddr_r <= ADDR_MEPC;
            data_r  <= inst_addr_i;
          end else if (mret_i) begin
            state_r <= W_MRET;
            we_r    <= 1'b1;
            waddr_r <= ADDR_MSTATUS;
            data_r  <= mret_mstatus(csr_mstatus_i);
          end else if (int_go_s) begin
            cause_r <= int_cause_s;
            state_r <= W_MEPC;
            we_r    <= 1'b1;
            waddr_r <= ADDR_MEPC;
            data_r  <= int_epc_s;
          end else begin
            state_r <= IDLE;
          end
        end
        W_MEPC: begin
          state_r <= W_MSTATUS;
          we_r    <= 1'b1;
          waddr_r <= ADDR_MSTATUS;
          data_r  <= trap_mstatus(csr_mstatus_i);
        end
        W_MSTATUS: begin
          state_r <= W_MCAUSE;
          we_r    <= 1'b1;
          waddr_r <= ADDR_MCAUSE;
          data_r  <= cause_r;
        end
        W_MCAUSE: begin
          state_r      <= ASSERT;
          int_assert_r <= 1'b1;
          int_addr_r   <= csr_mtvec_i;
        end
        W_MRET: begin
          state_r      <= ASSERT;
          int_assert_r <= 1'b1;
          int_addr_r   <= csr_mepc_i;
        end
        ASSERT: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl -- scoreboard bench for trap_ctrl. Each driven cycle pushes the
// expected output vector; a negedge monitor pops and compares it.
// ---------------------------------------------------------------------------
module tb_trap_ctrl;

  logic        clk;
  logic        rst;
  logic        ecall_i;
  logic        ebreak_i;
  logic        mret_i;
  logic [31:0] inst_addr_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [7:0]  int_flag_i;
  logic        global_int_en_i;
  logic [31:0] csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic [31:0] csr_mstatus_i;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [31:0] data_o;
  logic        hold_flag_o;
  logic        int_assert_o;
  logic [31:0] int_addr_o;

  trap_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .ecall_i         (ecall_i),
    .ebreak_i        (ebreak_i),
    .mret_i          (mret_i),
    .inst_addr_i     (inst_addr_i),
    .jump_flag_i     (jump_flag_i),
    .jump_addr_i     (jump_addr_i),
    .int_flag_i      (int_flag_i),
    .global_int_en_i (global_int_en_i),
    .csr_mtvec_i     (csr_mtvec_i),
    .csr_mepc_i      (csr_mepc_i),
    .csr_mstatus_i   (csr_mstatus_i),
    .we_o            (we_o),
    .waddr_o         (waddr_o),
    .data_o          (data_o),
    .hold_flag_o     (hold_flag_o),
    .int_assert_o    (int_assert_o),
    .int_addr_o      (int_addr_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] data;
    logic        hold;
    logic        ast;
    logic [31:0] addr;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   errors_r = 0;
  int   checks_r = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_r++;
    if (act !== exp) begin
      errors_r++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [31:0] waddr, input logic [31:0] data,
                              input logic hold, input logic ast, input logic [31:0] addr,
                              input string tag);
    exp_t e;
    e.we = we; e.waddr = waddr; e.data = data;
    e.hold = hold; e.ast = ast; e.addr = addr; e.tag = tag;
    return e;
  endfunction

  // Monitor: compare outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check_val({e.tag, ".we"},    {31'd0, we_o},         {31'd0, e.we});
      check_val({e.tag, ".waddr"}, waddr_o,               e.waddr);
      check_val({e.tag, ".data"},  data_o,                e.data);
      check_val({e.tag, ".hold"},  {31'd0, hold_flag_o},  {31'd0, e.hold});
      check_val({e.tag, ".ast"},   {31'd0, int_assert_o}, {31'd0, e.ast});
      check_val({e.tag, ".addr"},  int_addr_o,            e.addr);
    end
  end

  // Called just after a posedge with inputs already set for this cycle.
  task automatic step(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, tag));
  endtask

  // Trigger inputs are set by the caller. A stray mret during W_MEPC must be
  // ignored; MIE is dropped as the real CSR file would do after the mstatus write.
  task automatic run_trap(input logic [31:0] epc, input logic [31:0] ms_exp,
                          input logic [31:0] cause, input logic [31:0] mtvec, input string tag);
    step(mk(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, {tag, ".T0"}));
    ecall_i = 1'b0; ebreak_i = 1'b0; global_int_en_i = 1'b0; mret_i = 1'b1;
    step(mk(1'b1, 32'h341, epc, 1'b1, 1'b0, 32'h0, {tag, ".mepc"}));
    mret_i = 1'b0;
    step(mk(1'b1, 32'h300, ms_exp, 1'b1, 1'b0, 32'h0, {tag, ".mstatus"}));
    step(mk(1'b1, 32'h342, cause, 1'b1, 1'b0, 32'h0, {tag, ".mcause"}));
    step(mk(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, mtvec, {tag, ".redirect"}));
    step(mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, {tag, ".release"}));
  endtask

  initial begin
    rst = 1'b1; ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0;
    inst_addr_i = 32'h0; jump_flag_i = 1'b0; jump_addr_i = 32'h0;
    int_flag_i = 8'h00; global_int_en_i = 1'b0;
    csr_mtvec_i = 32'h200; csr_mepc_i = 32'h0; csr_mstatus_i = 32'h8;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2, "reset");

    // ecall
    inst_addr_i = 32'h100; ecall_i = 1'b1;
    run_trap(32'h100, 32'h80, 32'h0000000B, 32'h200, "ecall");

    // ebreak, with other mstatus bits that must pass through
    csr_mstatus_i = 32'h1808; inst_addr_i = 32'h124; ebreak_i = 1'b1;
    run_trap(32'h124, 32'h1880, 32'h00000003, 32'h200, "ebreak");

    // timer interrupt during an ex redirect
    csr_mstatus_i = 32'h8; inst_addr_i = 32'h100;
    jump_flag_i = 1'b1; jump_addr_i = 32'h40;
    int_flag_i = 8'h01; global_int_en_i = 1'b1;
    run_trap(32'h40, 32'h80, 32'h80000007, 32'h200, "timer");
    idle(2, "timer_lvl");

    // external interrupt, no redirect
    jump_flag_i = 1'b0; inst_addr_i = 32'h180; csr_mtvec_i = 32'h300;
    int_flag_i = 8'h04; global_int_en_i = 1'b1;
    run_trap(32'h180, 32'h80, 32'h8000000B, 32'h300, "ext");
    int_flag_i = 8'h00;

    // mret
    csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104; mret_i = 1'b1;
    step(mk(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, "mret.T0"));
    mret_i = 1'b0;
    step(mk(1'b1, 32'h300, 32'h88, 1'b1, 1'b0, 32'h0, "mret.mstatus"));
    step(mk(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h104, "mret.redirect"));
    step(mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, "mret.release"));

    // pending interrupt with MIE clear is never taken
    int_flag_i = 8'h01; global_int_en_i = 1'b0;
    idle(10, "masked");

    // ecall and interrupt together: ecall wins, mepc from inst_addr
    csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h200;
    inst_addr_i = 32'h300; jump_flag_i = 1'b1; jump_addr_i = 32'h999;
    ecall_i = 1'b1; global_int_en_i = 1'b1;
    run_trap(32'h300, 32'h80, 32'h0000000B, 32'h200, "both");
    idle(3, "both_lvl");
    int_flag_i = 8'h00; jump_flag_i = 1'b0;

    // reset during W_MSTATUS
    inst_addr_i = 32'h500; ecall_i = 1'b1;
    step(mk(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, "rst.T0"));
    ecall_i = 1'b0;
    step(mk(1'b1, 32'h341, 32'h500, 1'b1, 1'b0, 32'h0, "rst.mepc"));
    rst = 1'b1;
    step(mk(1'b1, 32'h300, 32'h80, 1'b1, 1'b0, 32'h0, "rst.mstatus"));
    rst = 1'b0;
    idle(5, "rst.after");

    check_val("q_left", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer; the initiator side of the CSR file's secondary (clint) write port.
- On ecall, ebreak, a pending enabled interrupt or mret, it stalls the pipeline and performs the mepc/mstatus/mcause writes or the mstatus restore as one CSR write per cycle.
- It then issues a redirect to mtvec or mepc.
- It sits beside ex; its hold output feeds the pipeline hold logic.

Parameters:
- CAUSE_ECALL, 32'h0000000B, mcause value for ecall
- CAUSE_EBREAK, 32'h00000003, mcause value for ebreak
- CAUSE_TIMER, 32'h80000007, mcause value for timer interrupt (int_flag_i[0])
- CAUSE_EXT, 32'h8000000B, mcause value for any other interrupt bit

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ecall_i  in  1  ecall in ex this cycle
- ebreak_i  in  1  ebreak in ex this cycle
- mret_i  in  1  mret in ex this cycle
- inst_addr_i  in  32  pc of instruction in ex
- jump_flag_i  in  1  ex is redirecting this cycle
- jump_addr_i  in  32  ex redirect target
- int_flag_i  in  8  level interrupt requests, bit0 = timer
- global_int_en_i  in  1  mstatus.MIE from CSR file
- csr_mtvec_i  in  32  current mtvec
- csr_mepc_i  in  32  current mepc
- csr_mstatus_i  in  32  current mstatus
- we_o  out  1  CSR write enable (clint port)
- waddr_o  out  32  CSR write address
- data_o  out  32  CSR write data
- hold_flag_o  out  1  pipeline stall request
- int_assert_o  out  1  redirect strobe, one cycle
- int_addr_o  out  32  redirect target

Behaviour:
- States: IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, W_MRET, ASSERT.
- Reset: state=IDLE, epc/cause regs=0. All outputs 0 in the cycle after rst is sampled high.
- Trigger evaluation happens in IDLE only, by priority:
  1. ecall_i / ebreak_i (ecall wins if both high)
  2. mret_i
  3. (int_flag_i != 0) && global_int_en_i
- On trigger, in the same cycle:
  - hold_flag_o=1 (combinational).
  - epc captured:
    - sync trap: epc = inst_addr_i
    - interrupt: epc = jump_flag_i ? jump_addr_i : inst_addr_i
  - cause captured: ecall -> CAUSE_ECALL; ebreak -> CAUSE_EBREAK; interrupt with int_flag_i[0] -> CAUSE_TIMER; otherwise CAUSE_EXT.
  - Next state: trap/interrupt -> W_MEPC; mret -> W_MRET.
- W_MEPC: we_o=1, waddr_o=32'h341, data_o=epc. Next W_MSTATUS.
- W_MSTATUS: we_o=1, waddr_o=32'h300.
  - data_o = csr_mstatus_i with bit7 (MPIE) = csr_mstatus_i[3] and bit3 (MIE) = 0; other bits unchanged.
  - Next W_MCAUSE.
- W_MCAUSE: we_o=1, waddr_o=32'h342, data_o=cause. Next ASSERT; int_addr_o target latched = csr_mtvec_i.
- W_MRET: we_o=1, waddr_o=32'h300.
  - data_o = csr_mstatus_i with bit3 = csr_mstatus_i[7] and bit7 = 1.
  - Next ASSERT; target latched = csr_mepc_i.
- ASSERT: int_assert_o=1, int_addr_o=target, we_o=0. Next IDLE.
- hold_flag_o=1 in every non-IDLE state and in an IDLE cycle with a trigger; otherwise 0.
- When we_o=0: waddr_o=0, data_o=0. When int_assert_o=0: int_addr_o=0.
- Latency:
  - trap: trigger T; writes T+1..T+3; redirect T+4; hold released T+5.
  - mret: write T+1; redirect T+2.
- Events arriving outside IDLE are ignored. Interrupts are level inputs and are re-evaluated on return to IDLE.
- Because MIE is cleared in W_MSTATUS, an interrupt does not immediately retrigger.
- int_flag_i with global_int_en_i=0 is never taken; no hold.
- The CSR file prioritises ex writes over the clint port. The pipeline suppresses ex CSR writes while hold_flag_o=1.
- Reset mid-sequence: immediate return to IDLE with outputs 0. No redirect. CSRs already written keep their values.

Test Plan:
- ecall, inst_addr_i=0x100, mtvec=0x200, mstatus=0x8 -> writes 0x341<=0x100, 0x300<=0x80, 0x342<=0xB on T+1..T+3; T+4 int_assert_o=1, int_addr_o=0x200; hold high T..T+4.
- int_flag_i=0x01, MIE=1, jump_flag_i=1, jump_addr_i=0x40 -> mepc<=0x40, mcause<=0x80000007, redirect to mtvec. Repeat with int_flag_i=0x04 -> mcause<=0x8000000B.
- mret, mstatus=0x80, mepc=0x104 -> T+1 0x300<=0x88; T+2 int_assert_o=1, int_addr_o=0x104; hold released T+3.
- int_flag_i=0x01, MIE=0 for 10 cycles -> we_o, hold_flag_o and int_assert_o stay 0.
- ecall and int_flag_i=0x01 in the same cycle -> cause 0xB and mepc=inst_addr_i. With int_flag_i still high after IDLE but MIE=0, no second trap.
- rst pulsed during W_MSTATUS -> next cycle all outputs 0, state IDLE, no int_assert_o.
